mbist_seq_fsm: RTL and testbench

MBIST_SEQ_FSM -- requirements
Module: mbist_seq_fsm

---
 rtl/mbist_seq_fsm.sv | 94 +++++++++
 tb/tb_mbist_seq_fsm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mbist_seq_fsm.sv
// mbist_seq_fsm: MBIST CMD/WAIT/CMP phase sequencer; define MBIST_ERR_DIAG_EN to enable stop_on_err and err_cnt
module mbist_seq_fsm #(
  parameter int RD_LAT     = 1,
  parameter int ERR_CNT_WD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bist_run,
  input  logic                  stop_on_err,
  input  logic                  cmp_err,
  input  logic                  op_reverse,
  input  logic                  last_op,
  input  logic                  last_addr,
  input  logic                  last_sti,
  input  logic                  last_pat,
  output logic                  cmd_phase,
  output logic                  wait_phase,
  output logic                  cmp_phase,
  output logic                  run_op,
  output logic                  run_addr,
  output logic                  run_sti,
  output logic                  run_pat,
  output logic                  bist_done,
  output logic                  bist_busy,
  output logic [ERR_CNT_WD-1:0] err_cnt
);
  typedef enum logic [2:0] {IDLE, CMD, WAIT, CMP, DONE} state_t;
  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT > 1 ? RD_LAT - 2 : 0);
  state_t     state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic       term_q, term_d;
  logic [8:0] out_q, out_d;
  logic       stop, all_last, enter_cmp;
  assign all_last  = last_op & last_addr & last_sti & last_pat;
  assign enter_cmp = state_d == CMP;
  assign {cmd_phase, wait_phase, cmp_phase, run_op, run_addr, run_sti, run_pat, bist_done, bist_busy} = out_q;
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (!bist_run) begin
      state_d = IDLE;
      wcnt_d  = '0;
    end else if (stop && cmp_err && state_q inside {CMD, WAIT, CMP}) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          state_d = RD_LAT > 1 ? WAIT : CMP;
          wcnt_d  = WAIT_INIT;
        end
        WAIT: begin
          state_d = wcnt_q == '0 ? CMP : WAIT;
          wcnt_d  = wcnt_q == '0 ? '0 : wcnt_q - 3'd1;
        end
        CMP:     state_d = term_q ? DONE : CMD;
        default: state_d = state_q;
      endcase
    end
    term_d = enter_cmp ? all_last : term_q;
    out_d  = {state_d == CMD, state_d == WAIT, state_d == CMP,
              enter_cmp & ~all_last,
              enter_cmp & ~all_last & last_op & ~(last_addr & op_reverse),
              enter_cmp & ~all_last & last_op & last_addr,
              enter_cmp & ~all_last & last_op & last_addr & last_sti,
              state_d == DONE, state_d inside {CMD, WAIT, CMP}};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      term_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      term_q  <= term_d;
      out_q   <= out_d;
    end
`ifdef MBIST_ERR_DIAG_EN
  logic [ERR_CNT_WD-1:0] err_q, err_d;
  assign stop    = stop_on_err;
  assign err_cnt = err_q;
  always_comb
    err_d = state_q == IDLE && bist_run ? '0 :
            cmp_err && ~&err_q          ? err_q + ERR_CNT_WD'(1) : err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
`else
  assign stop    = stop_on_err | 1'b1;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_mbist_seq_fsm.sv
// tb_mbist_seq_fsm: table vectors, corner sequences and random run against a phase-position reference model
module tb_mbist_seq_fsm;
`ifdef MBIST_ERR_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif
  typedef struct { int mode; int pos; bit term; logic [3:0] runs; int err; } mdl_t;
  typedef struct { logic [7:0] in; logic [8:0] exp; } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic r = 0, s = 0, e = 0, lo = 0, la = 0, ls = 0, lp = 0, rev = 0;
  wire [8:0] o1, o3;
  wire [7:0] e1;
  wire [1:0] e3;
  int n_cmp = 0, n_bad = 0;
  mdl_t m1, m3;
  always #5 clk = ~clk;
  mbist_seq_fsm #(.RD_LAT(1), .ERR_CNT_WD(8)) u1 (
    .clk(clk), .rst_n(rst_n), .bist_run(r), .stop_on_err(s), .cmp_err(e), .op_reverse(rev),
    .last_op(lo), .last_addr(la), .last_sti(ls), .last_pat(lp),
    .cmd_phase(o1[8]), .wait_phase(o1[7]), .cmp_phase(o1[6]), .run_op(o1[5]), .run_addr(o1[4]),
    .run_sti(o1[3]), .run_pat(o1[2]), .bist_done(o1[1]), .bist_busy(o1[0]), .err_cnt(e1));
  mbist_seq_fsm #(.RD_LAT(3), .ERR_CNT_WD(2)) u3 (
    .clk(clk), .rst_n(rst_n), .bist_run(r), .stop_on_err(s), .cmp_err(e), .op_reverse(rev),
    .last_op(lo), .last_addr(la), .last_sti(ls), .last_pat(lp),
    .cmd_phase(o3[8]), .wait_phase(o3[7]), .cmp_phase(o3[6]), .run_op(o3[5]), .run_addr(o3[4]),
    .run_sti(o3[3]), .run_pat(o3[2]), .bist_done(o3[1]), .bist_busy(o3[0]), .err_cnt(e3));
  function automatic mdl_t mzero();
    mdl_t z;
    z.mode = 0; z.pos = 0; z.term = 0; z.runs = '0; z.err = 0;
    return z;
  endfunction
  // mode: 0 idle, 1 running (pos = cycles since CMD), 2 done
  function automatic mdl_t step(mdl_t m, int lat, int maxe, logic rr, logic ss, logic ee,
                                logic o, logic a, logic t, logic p, logic v);
    mdl_t n = m;
    if (DIAG) begin
      if (m.mode == 0 && rr) n.err = 0;
      else if (ee && m.err < maxe) n.err = m.err + 1;
    end
    n.runs = '0;
    if (!rr) begin
      n.mode = 0; n.pos = 0;
    end else if (m.mode == 1 && ee && (DIAG ? ss : 1'b1)) begin
      n.mode = 2;
    end else if (m.mode == 0) begin
      n.mode = 1; n.pos = 0;
    end else if (m.mode == 1) begin
      if (m.pos == lat) begin
        if (m.term) n.mode = 2;
        else n.pos = 0;
      end else n.pos = m.pos + 1;
      if (n.mode == 1 && n.pos == lat) begin
        n.term = o & a & t & p;
        n.runs = n.term ? 4'b0 : {1'b1, o & ~(a & v), o & a, o & a & t};
      end
    end
    return n;
  endfunction
  function automatic logic [8:0] mout(mdl_t m, int lat);
    return {m.mode == 1 && m.pos == 0, m.mode == 1 && m.pos > 0 && m.pos < lat,
            m.mode == 1 && m.pos == lat, m.runs, m.mode == 2, m.mode == 1};
  endfunction
  task automatic chk(string nm, logic [15:0] got, logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    m1 = step(m1, 1, 255, r, s, e, lo, la, ls, lp, rev);
    m3 = step(m3, 3, 3, r, s, e, lo, la, ls, lp, rev);
    #1;
    chk("u1_out", 16'(o1), 16'(mout(m1, 1)));
    chk("u1_err", 16'(e1), 16'(m1.err));
    chk("u3_out", 16'(o3), 16'(mout(m3, 3)));
    chk("u3_err", 16'(e3), 16'(m3.err));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl[16];
    logic [2:0] ph[5];
    int k;
    // {run,stop,err,last_op,last_addr,last_sti,last_pat,rev} -> {cmd,wait,cmp,op,addr,sti,pat,done,busy}
    tbl = '{'{8'b1000_0000, 9'b100_0000_01}, '{8'b1000_0000, 9'b001_1000_01},
            '{8'b1000_0000, 9'b100_0000_01}, '{8'b1000_0000, 9'b001_1000_01},
            '{8'b1000_0000, 9'b100_0000_01}, '{8'b1000_0000, 9'b001_1000_01},
            '{8'b1000_0000, 9'b100_0000_01}, '{8'b1001_0000, 9'b001_1100_01},
            '{8'b1000_0000, 9'b100_0000_01}, '{8'b1001_1001, 9'b001_1010_01},
            '{8'b1000_0000, 9'b100_0000_01}, '{8'b1001_1110, 9'b001_0000_01},
            '{8'b1000_0000, 9'b000_0000_10}, '{8'b1000_0000, 9'b000_0000_10},
            '{8'b0000_0000, 9'b000_0000_00}, '{8'b0000_0000, 9'b000_0000_00}};
    ph = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b100};
    m1 = mzero();
    m3 = mzero();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_u1", 16'(o1), 16'd0);
    chk("rst_u3", 16'(o3), 16'd0);
    chk("rst_e1", 16'(e1), 16'd0);
    chk("rst_e3", 16'(e3), 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      {r, s, e, lo, la, ls, lp, rev} = tbl[i].in;
      tick();
      chk($sformatf("vec%0d", i), 16'(o1), 16'(tbl[i].exp));
      chk($sformatf("vec%0d_err", i), 16'(e1), 16'd0);
    end
    r = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("lat3_ph%0d", i), 16'(o3[8:6]), 16'(ph[i]));
    end
    r = 0; tick();
    r = 1; tick(); tick();
    s = 1; e = 1; tick();
    chk("stop_wait_done", 16'(o3), 16'(9'b000_0000_10));
    chk("stop_wait_err", 16'(e3), DIAG ? 16'd1 : 16'd0);
    s = 0; e = 0; r = 0; tick();
    r = 1; tick();
    for (int i = 0; i < 5; i++) begin
      e = 1; tick();
      e = 0; tick();
    end
    {lo, la, ls, lp} = 4'hf;
    k = 0;
    while (!o3[1] && k < 40) begin
      tick();
      k++;
    end
    chk("diag_done", 16'(o3[1]), 16'd1);
    chk("diag_err_sat", 16'(e3), DIAG ? 16'd3 : 16'd0);
    {lo, la, ls, lp} = 4'h0;
    r = 0; tick();
    r = 1; tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_u1", 16'(o1), 16'd0);
    chk("async_rst_u3", 16'(o3), 16'd0);
    m1 = mzero();
    m3 = mzero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("restart_cmd", 16'(o3[8]), 16'd1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 19) != 0;
      s = 1'($urandom_range(0, 1));
      e = (m1.mode != 0 && m3.mode != 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
      lo = 1'($urandom_range(0, 1));
      la = 1'($urandom_range(0, 1));
      ls = 1'($urandom_range(0, 1));
      lp = 1'($urandom_range(0, 1));
      rev = 1'($urandom_range(0, 1));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
